// File: rtl/bp_mem_sram_bridge.sv
// Memory-side endpoint: runs one packed mem command as 1..N word beats on a
// single-port synchronous SRAM and returns one packed mem response.
module bp_mem_sram_bridge #(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int word_width_p    = 64,
  parameter int payload_width_p = 16,
  parameter int sram_els_p      = 4096,
  localparam int msg_width_lp   = 4 + paddr_width_p + 3 + payload_width_p + block_width_p,
  localparam int sram_aw_lp     = $clog2(sram_els_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [msg_width_lp-1:0]   mem_cmd_i,
  input  logic                      mem_cmd_v_i,
  output logic                      mem_cmd_ready_o,
  output logic [msg_width_lp-1:0]   mem_resp_o,
  output logic                      mem_resp_v_o,
  input  logic                      mem_resp_yumi_i,
  output logic                      sram_v_o,
  output logic                      sram_w_o,
  output logic [sram_aw_lp-1:0]     sram_addr_o,
  output logic [word_width_p-1:0]   sram_data_o,
  output logic [word_width_p/8-1:0] sram_mask_o,
  input  logic [word_width_p-1:0]   sram_data_i
);

  localparam int word_bytes_lp    = word_width_p / 8;
  localparam int lg_word_bytes_lp = $clog2(word_bytes_lp);
  localparam int max_beats_lp     = block_width_p / word_width_p;
  localparam int lg_max_beats_lp  = $clog2(max_beats_lp);
  localparam int cnt_w_lp         = lg_max_beats_lp + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DRAIN, S_RESP} state_e;

  state_e                        r_state;
  logic [3:0]                    r_type;
  logic [paddr_width_p-1:0]      r_addr;
  logic [2:0]                    r_size;
  logic [payload_width_p-1:0]    r_payload;
  logic [block_width_p-1:0]      r_cmd_data;
  logic [block_width_p-1:0]      r_resp_data;
  logic [cnt_w_lp-1:0]           r_beats;
  logic [cnt_w_lp-1:0]           r_cnt;
  logic [lg_max_beats_lp-1:0]    r_cap_idx;
  logic [sram_aw_lp-1:0]         r_base;
  logic [lg_word_bytes_lp-1:0]   r_byte_off;
  logic                          r_rd_pend;
  logic                          r_ready;
  logic                          r_resp_v;
  logic                          r_sram_v;
  logic                          r_sram_w;
  logic [sram_aw_lp-1:0]         r_sram_addr;
  logic [word_width_p-1:0]       r_sram_data;
  logic [word_bytes_lp-1:0]      r_sram_mask;

  logic [3:0]                    w_cmd_type;
  logic [paddr_width_p-1:0]      w_cmd_addr;
  logic [2:0]                    w_cmd_size;
  logic [payload_width_p-1:0]    w_cmd_payload;
  logic [block_width_p-1:0]      w_cmd_data;
  logic [cnt_w_lp-1:0]           w_beats;
  logic [sram_aw_lp-1:0]         w_word_idx;
  logic [sram_aw_lp-1:0]         w_base;
  logic [lg_word_bytes_lp-1:0]   w_size_mask;
  logic [lg_word_bytes_lp-1:0]   w_byte_off;
  logic                          w_known;
  logic                          w_is_wr;
  logic [lg_max_beats_lp-1:0]    w_wr_idx;
  logic [word_width_p-1:0]       w_wr_word;
  logic [word_width_p-1:0]       w_wr_data;
  logic [word_bytes_lp-1:0]      w_mask;

  assign w_cmd_type    = mem_cmd_i[3:0];
  assign w_cmd_addr    = mem_cmd_i[4 +: paddr_width_p];
  assign w_cmd_size    = mem_cmd_i[4 + paddr_width_p +: 3];
  assign w_cmd_payload = mem_cmd_i[7 + paddr_width_p +: payload_width_p];
  assign w_cmd_data    = mem_cmd_i[7 + paddr_width_p + payload_width_p +: block_width_p];

  // Beat count of the incoming command, clamped so it never exceeds one block.
  always_comb begin
    w_beats = cnt_w_lp'(1);
    if (int'(w_cmd_size) > lg_word_bytes_lp) begin
      if (int'(w_cmd_size) - lg_word_bytes_lp >= lg_max_beats_lp) begin
        w_beats = cnt_w_lp'(max_beats_lp);
      end else begin
        w_beats = cnt_w_lp'(1) << (int'(w_cmd_size) - lg_word_bytes_lp);
      end
    end else begin
      w_beats = cnt_w_lp'(1);
    end
  end

  // Word index wraps modulo the SRAM depth by truncation; base and byte offset
  // are aligned down to the transfer size.
  assign w_word_idx  = w_cmd_addr[lg_word_bytes_lp +: sram_aw_lp];
  assign w_base      = w_word_idx & ~sram_aw_lp'(w_beats - cnt_w_lp'(1));
  assign w_size_mask = lg_word_bytes_lp'((32'd1 << w_cmd_size) - 32'd1);
  assign w_byte_off  = w_cmd_addr[lg_word_bytes_lp-1:0] & ~w_size_mask;

  assign w_known   = (r_type < 4'd4);
  assign w_is_wr   = r_type[0];
  assign w_wr_idx  = r_cnt[lg_max_beats_lp-1:0];
  assign w_wr_word = r_cmd_data[w_wr_idx*word_width_p +: word_width_p];
  // Sub-word writes move the low bytes onto their byte lanes.
  assign w_wr_data = w_wr_word << {r_byte_off, 3'b000};

  // Byte write mask for the current beat.
  always_comb begin
    w_mask = {word_bytes_lp{1'b1}};
    if (int'(r_size) < lg_word_bytes_lp) begin
      w_mask = word_bytes_lp'((32'd1 << (32'd1 << r_size)) - 32'd1) << r_byte_off;
    end else begin
      w_mask = {word_bytes_lp{1'b1}};
    end
  end

  // Bridge FSM: command latch, beat issue, read capture and response hold.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_type      <= 4'd0;
      r_addr      <= '0;
      r_size      <= 3'd0;
      r_payload   <= '0;
      r_cmd_data  <= '0;
      r_resp_data <= '0;
      r_beats     <= '0;
      r_cnt       <= '0;
      r_cap_idx   <= '0;
      r_base      <= '0;
      r_byte_off  <= '0;
      r_rd_pend   <= 1'b0;
      r_ready     <= 1'b1;
      r_resp_v    <= 1'b0;
      r_sram_v    <= 1'b0;
      r_sram_w    <= 1'b0;
      r_sram_addr <= '0;
      r_sram_data <= '0;
      r_sram_mask <= '0;
    end else begin
      r_rd_pend <= r_sram_v & ~r_sram_w;
      if (r_rd_pend) begin
        r_resp_data[r_cap_idx*word_width_p +: word_width_p] <= sram_data_i;
        r_cap_idx <= r_cap_idx + lg_max_beats_lp'(1);
      end
      case (r_state)
        S_IDLE: begin
          r_sram_v <= 1'b0;
          if (mem_cmd_v_i) begin
            r_type      <= w_cmd_type;
            r_addr      <= w_cmd_addr;
            r_size      <= w_cmd_size;
            r_payload   <= w_cmd_payload;
            r_cmd_data  <= w_cmd_data;
            r_beats     <= w_beats;
            r_base      <= w_base;
            r_byte_off  <= w_byte_off;
            r_cnt       <= '0;
            r_cap_idx   <= '0;
            r_resp_data <= '0;
            r_ready     <= 1'b0;
            r_state     <= S_ACCESS;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (!w_known) begin
            r_sram_v <= 1'b0;
            r_resp_v <= 1'b1;
            r_state  <= S_RESP;
          end else if (r_cnt != r_beats) begin
            r_sram_v    <= 1'b1;
            r_sram_w    <= w_is_wr;
            r_sram_addr <= r_base + sram_aw_lp'(r_cnt);
            r_sram_data <= w_is_wr ? w_wr_data : '0;
            r_sram_mask <= w_is_wr ? w_mask : '0;
            r_cnt       <= r_cnt + cnt_w_lp'(1);
          end else begin
            r_sram_v <= 1'b0;
            if (w_is_wr) begin
              r_resp_v <= 1'b1;
              r_state  <= S_RESP;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_sram_v <= 1'b0;
          r_resp_v <= 1'b1;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          r_sram_v <= 1'b0;
          if (mem_resp_yumi_i) begin
            r_resp_v <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_resp_v <= 1'b1;
          end
        end
        default: begin
          r_sram_v <= 1'b0;
          r_resp_v <= 1'b0;
          r_ready  <= 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_cmd_ready_o = r_ready;
  assign mem_resp_v_o    = r_resp_v;
  assign mem_resp_o      = {r_resp_data, r_payload, r_size, r_addr, r_type};
  assign sram_v_o        = r_sram_v;
  assign sram_w_o        = r_sram_w;
  assign sram_addr_o     = r_sram_addr;
  assign sram_data_o     = r_sram_data;
  assign sram_mask_o     = r_sram_mask;

endmodule

// File: tb/tb_bp_mem_sram_bridge.sv
// Directed bench for bp_mem_sram_bridge with a behavioural byte-masked SRAM.
module tb_bp_mem_sram_bridge;

  localparam int MSG = 4 + 40 + 3 + 16 + 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [MSG-1:0]  mem_cmd_i;
  logic            mem_cmd_v_i;
  logic            mem_cmd_ready_o;
  logic [MSG-1:0]  mem_resp_o;
  logic            mem_resp_v_o;
  logic            mem_resp_yumi_i;
  logic            sram_v_o;
  logic            sram_w_o;
  logic [11:0]     sram_addr_o;
  logic [63:0]     sram_data_o;
  logic [7:0]      sram_mask_o;
  logic [63:0]     sram_data_i;

  bit   [63:0]     mem [4096];
  bit   [63:0]     rdata;
  int              sram_cnt;
  logic [7:0]      last_mask;

  int n_vec  = 0;
  int n_miss = 0;

  bp_mem_sram_bridge dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .mem_cmd_i       (mem_cmd_i),
    .mem_cmd_v_i     (mem_cmd_v_i),
    .mem_cmd_ready_o (mem_cmd_ready_o),
    .mem_resp_o      (mem_resp_o),
    .mem_resp_v_o    (mem_resp_v_o),
    .mem_resp_yumi_i (mem_resp_yumi_i),
    .sram_v_o        (sram_v_o),
    .sram_w_o        (sram_w_o),
    .sram_addr_o     (sram_addr_o),
    .sram_data_o     (sram_data_o),
    .sram_mask_o     (sram_mask_o),
    .sram_data_i     (sram_data_i)
  );

  always #5 clk = ~clk;
  assign sram_data_i = rdata;

  // Synchronous single-port SRAM with byte mask, read data one cycle later.
  always @(posedge clk) begin
    if (sram_v_o) begin
      sram_cnt  <= sram_cnt + 1;
      last_mask <= sram_mask_o;
      if (sram_w_o) begin
        for (int b = 0; b < 8; b++)
          if (sram_mask_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_data_o[b*8 +: 8];
      end else begin
        rdata <= mem[sram_addr_o];
      end
    end
  end

  // Consumer-side protocol rule: never take a response that is not offered.
  always @(posedge clk)
    if (rst_n) assert (!(mem_resp_yumi_i && !mem_resp_v_o)) else $error("yumi asserted with no response");

  task automatic chk(input string tag, input logic [MSG-1:0] obs, input logic [MSG-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MSG-1:0] mk(input logic [3:0] t, input logic [39:0] a,
                                        input logic [2:0] s, input logic [15:0] p,
                                        input logic [511:0] d);
    return {d, p, s, a, t};
  endfunction

  task automatic do_cmd(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                        input logic [15:0] p, input logic [511:0] d, output int lat);
    mem_cmd_i   = mk(t, a, s, p, d);
    mem_cmd_v_i = 1'b1;
    @(posedge clk); #1;
    mem_cmd_v_i = 1'b0;
    lat = 0;
    while (!mem_resp_v_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_resp();
    mem_resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    mem_resp_yumi_i = 1'b0;
  endtask

  initial begin
    int          lat;
    int          cnt0;
    int          vcnt;
    logic [511:0] blk;
    logic [MSG-1:0] exp_resp;

    for (int i = 0; i < 8; i++) blk[i*64 +: 64] = 64'h0123_4567_89AB_CD00 | 64'(i);

    // 1: reset held with a command pending
    rst_n = 1'b0; mem_resp_yumi_i = 1'b0;
    mem_cmd_v_i = 1'b1; mem_cmd_i = mk(4'd1, 40'h80, 3'd6, 16'h1, blk);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", MSG'(mem_cmd_ready_o), MSG'(1'b1));
    chk("rst_resp_v", MSG'(mem_resp_v_o), MSG'(1'b0));
    chk("rst_sram_cnt", MSG'(sram_cnt), MSG'(0));
    mem_cmd_v_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", MSG'(mem_cmd_ready_o), MSG'(1'b1));

    // 2: full-block write
    cnt0 = sram_cnt;
    do_cmd(4'd1, 40'h80, 3'd6, 16'h1234, blk, lat);
    chk("wr_lat", MSG'(lat), MSG'(9));
    chk("wr_resp", mem_resp_o, mk(4'd1, 40'h80, 3'd6, 16'h1234, 512'd0));
    chk("wr_beats", MSG'(sram_cnt - cnt0), MSG'(8));
    for (int i = 0; i < 8; i++) chk($sformatf("wr_mem%0d", 16 + i), MSG'(mem[16 + i]), MSG'(blk[i*64 +: 64]));
    take_resp();

    // 3: full-block read-back
    cnt0 = sram_cnt;
    do_cmd(4'd0, 40'h80, 3'd6, 16'hBEEF, 512'd0, lat);
    chk("rd_lat", MSG'(lat), MSG'(10));
    chk("rd_resp", mem_resp_o, mk(4'd0, 40'h80, 3'd6, 16'hBEEF, blk));
    chk("rd_beats", MSG'(sram_cnt - cnt0), MSG'(8));
    take_resp();

    // 4: uncached byte write, then word read
    do_cmd(4'd3, 40'h103, 3'd0, 16'h0042, 512'hAB, lat);
    chk("ucwr_lat", MSG'(lat), MSG'(2));
    chk("ucwr_mask", MSG'(last_mask), MSG'(8'b0000_1000));
    chk("ucwr_resp", mem_resp_o, mk(4'd3, 40'h103, 3'd0, 16'h0042, 512'd0));
    take_resp();
    do_cmd(4'd2, 40'h100, 3'd3, 16'h0043, 512'd0, lat);
    chk("ucrd_lat", MSG'(lat), MSG'(3));
    chk("ucrd_resp", mem_resp_o, mk(4'd2, 40'h100, 3'd3, 16'h0043, 512'hAB00_0000));
    take_resp();

    // 5: response held without yumi; a competing command must be ignored
    do_cmd(4'd0, 40'h88, 3'd3, 16'h0055, 512'd0, lat);
    exp_resp = mk(4'd0, 40'h88, 3'd3, 16'h0055, {448'd0, blk[127:64]});
    chk("hold_lat", MSG'(lat), MSG'(3));
    cnt0 = sram_cnt;
    mem_cmd_i = mk(4'd1, 40'h0, 3'd6, 16'h0, {8{64'hDEAD}});
    mem_cmd_v_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("hold_resp", mem_resp_o, exp_resp);
      chk("hold_ready", MSG'({mem_cmd_ready_o, mem_resp_v_o}), MSG'(2'b01));
    end
    chk("hold_no_sram", MSG'(sram_cnt - cnt0), MSG'(0));
    mem_cmd_v_i = 1'b0;
    take_resp();
    chk("yumi_idle", MSG'({mem_cmd_ready_o, mem_resp_v_o}), MSG'(2'b10));
    chk("no_stray_wr", MSG'(mem[0]), MSG'(64'd0));

    // 6a: unknown message type
    cnt0 = sram_cnt;
    do_cmd(4'd7, 40'h80, 3'd6, 16'h0777, blk, lat);
    chk("unk_lat", MSG'(lat), MSG'(1));
    chk("unk_resp", mem_resp_o, mk(4'd7, 40'h80, 3'd6, 16'h0777, 512'd0));
    chk("unk_no_sram", MSG'(sram_cnt - cnt0), MSG'(0));
    take_resp();

    // 6b: reset in the middle of a block read
    mem_cmd_i = mk(4'd0, 40'h80, 3'd6, 16'h0999, 512'd0);
    mem_cmd_v_i = 1'b1;
    @(posedge clk); #1;
    mem_cmd_v_i = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_resp_v_o) vcnt++;
    end
    chk("rst_mid_no_resp", MSG'(vcnt), MSG'(0));
    chk("rst_mid_ready", MSG'(mem_cmd_ready_o), MSG'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
